// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg
// Shared definitions for the UART register-access protocol, used by the
// initiator (uart_reg_master) and the responder (uart_reg_if).
//   CMD_START / CMD_WRITE / CMD_READ : protocol command bytes
//   state_t                          : initiator sequencing states
package uart_reg_pkg;

    localparam logic [7:0] CMD_START = 8'h53;  // 'S'
    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_S,
        ST_TX_IDX,
        ST_TX_CMD,
        ST_TX_DATA,
        ST_RX_DATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/uart_reg_master_timer.sv
// uart_reg_master_timer
// Read-back watchdog: a down-counter that reloads to LOAD_VALUE on load,
// decrements on tick and flags expired when it reaches zero.
// The module only exists when UART_REG_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clock   in  system clock, rising edge
//   arst_n  in  asynchronous active-low reset
//   load    in  reload the counter to LOAD_VALUE (wins over tick)
//   tick    in  count down by one
//   expired out counter is at zero
`ifdef UART_REG_MASTER_TIMEOUT_EN
module uart_reg_master_timer #(
    parameter int LOAD_VALUE = 65535
) (
    input  logic clock,
    input  logic arst_n,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int WIDTH = $clog2(LOAD_VALUE + 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(LOAD_VALUE);
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule
`endif

// File: rtl/uart_reg_master.sv
// uart_reg_master
// Initiator side of the UART register-access protocol. A parallel request is
// sent as 'S', index, 'W'/'R', then (write) the data bytes LSB first; a read
// collects NUM_BYTES_PER_REG bytes from the receiver into rsp_rdata.
// Optional feature macro: UART_REG_MASTER_TIMEOUT_EN adds a read-back watchdog
// (TIMEOUT_CYCLES between received bytes); without it RX_DATA waits forever.
// Ports:
//   clock, arst_n               clock and asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_write/index/wdata       request contents, wdata byte 0 = bits [7:0]
//   rsp_valid/error/rdata       one-cycle completion, error flag, read data
//   uart_tx_value/_write/_done  transmitter byte, start strobe, finish pulse
//   uart_rx_value/_ready        receiver byte and its valid pulse
module uart_reg_master
    import uart_reg_pkg::*;
#(
    parameter int NUM_BYTES_PER_REG = 4,
    parameter int NUM_REGISTERS     = 8,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  logic                           clock,
    input  logic                           arst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [7:0]                     req_index,
    input  logic [8*NUM_BYTES_PER_REG-1:0] req_wdata,
    output logic                           rsp_valid,
    output logic                           rsp_error,
    output logic [8*NUM_BYTES_PER_REG-1:0] rsp_rdata,
    output logic [7:0]                     uart_tx_value,
    output logic                           uart_tx_value_write,
    input  logic                           uart_tx_value_done,
    input  logic [7:0]                     uart_rx_value,
    input  logic                           uart_rx_value_ready
);

    localparam int DW = 8 * NUM_BYTES_PER_REG;
    localparam int CW = $clog2(NUM_BYTES_PER_REG + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES_PER_REG - 1);

    state_t          state, next_state;
    logic            write_q;
    logic [7:0]      index_q;
    logic [DW-1:0]   wdata_q;
    logic [CW-1:0]   byte_cnt;
    logic [CW-1:0]   next_cnt;

    logic            accept;
    logic            tx_done;
    logic            tx_load;
    logic [7:0]      tx_byte;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            rx_clear;
    logic            rx_store;
    logic            resp_err;
    logic            timeout;

    assign accept   = req_valid && req_ready && (state == ST_IDLE);
    // A done pulse in the strobe cycle itself cannot belong to this byte.
    assign tx_done  = uart_tx_value_done && !uart_tx_value_write;
    assign next_cnt = byte_cnt + 1'b1;
    assign rsp_valid = (state == ST_RESP);

`ifdef UART_REG_MASTER_TIMEOUT_EN
    uart_reg_master_timer #(
        .LOAD_VALUE (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .arst_n  (arst_n),
        .load    (rx_clear || rx_store),
        .tick    (state == ST_RX_DATA),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        tx_load    = 1'b0;
        tx_byte    = 8'h00;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        rx_clear   = 1'b0;
        rx_store   = 1'b0;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (int'(req_index) >= NUM_REGISTERS) begin
                        next_state = ST_RESP;
                        resp_err   = 1'b1;
                    end else begin
                        next_state = ST_TX_S;
                        tx_load    = 1'b1;
                        tx_byte    = CMD_START;
                    end
                end
            end
            ST_TX_S: begin
                if (tx_done) begin
                    next_state = ST_TX_IDX;
                    tx_load    = 1'b1;
                    tx_byte    = index_q;
                end
            end
            ST_TX_IDX: begin
                if (tx_done) begin
                    next_state = ST_TX_CMD;
                    tx_load    = 1'b1;
                    tx_byte    = write_q ? CMD_WRITE : CMD_READ;
                end
            end
            ST_TX_CMD: begin
                if (tx_done) begin
                    cnt_clr = 1'b1;
                    if (write_q) begin
                        next_state = ST_TX_DATA;
                        tx_load    = 1'b1;
                        tx_byte    = wdata_q[7:0];
                    end else begin
                        next_state = ST_RX_DATA;
                        rx_clear   = 1'b1;
                    end
                end
            end
            ST_TX_DATA: begin
                if (tx_done) begin
                    if (byte_cnt == LAST_BYTE) begin
                        next_state = ST_RESP;
                    end else begin
                        tx_load = 1'b1;
                        tx_byte = wdata_q[8*int'(next_cnt) +: 8];
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_RX_DATA: begin
                if (uart_rx_value_ready) begin
                    rx_store = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        next_state = ST_RESP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (timeout) begin
                    next_state = ST_RESP;
                    resp_err   = 1'b1;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            req_ready           <= 1'b0;
            rsp_error           <= 1'b0;
            rsp_rdata           <= '0;
            uart_tx_value       <= 8'h00;
            uart_tx_value_write <= 1'b0;
            write_q             <= 1'b0;
            index_q             <= 8'h00;
            wdata_q             <= '0;
            byte_cnt            <= '0;
        end else begin
            // Registered so ready stays low while reset is asserted.
            req_ready           <= (next_state == ST_IDLE);
            uart_tx_value_write <= tx_load;
            if (tx_load) begin
                uart_tx_value <= tx_byte;
            end
            if (accept) begin
                write_q <= req_write;
                index_q <= req_index;
                wdata_q <= req_wdata;
            end
            if (cnt_clr) begin
                byte_cnt <= '0;
            end else if (cnt_inc) begin
                byte_cnt <= next_cnt;
            end
            if (rx_clear) begin
                rsp_rdata <= '0;
            end else if (rx_store) begin
                rsp_rdata[8*int'(byte_cnt) +: 8] <= uart_rx_value;
            end
            if (next_state == ST_RESP) begin
                rsp_error <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master
// Random and directed register requests against a behavioural model of the
// protocol and a remote register file reached through a modelled UART pair.
module tb_uart_reg_master;

    localparam int N    = 4;
    localparam int NREG = 8;
    localparam int TO   = 100;
    localparam int DW   = 8 * N;

    logic          clock = 1'b0;
    logic          arst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [7:0]    req_index = 8'h00;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic [7:0]    uart_tx_value;
    logic          uart_tx_value_write;
    logic          uart_tx_value_done = 1'b0;
    logic [7:0]    uart_rx_value = 8'h00;
    logic          uart_rx_value_ready = 1'b0;

    uart_reg_master #(
        .NUM_BYTES_PER_REG (N),
        .NUM_REGISTERS     (NREG),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clock               (clock),
        .arst_n              (arst_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_index           (req_index),
        .req_wdata           (req_wdata),
        .rsp_valid           (rsp_valid),
        .rsp_error           (rsp_error),
        .rsp_rdata           (rsp_rdata),
        .uart_tx_value       (uart_tx_value),
        .uart_tx_value_write (uart_tx_value_write),
        .uart_tx_value_done  (uart_tx_value_done),
        .uart_rx_value       (uart_rx_value),
        .uart_rx_value_ready (uart_rx_value_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic [7:0]    exp_tx[$];
    rsp_t          exp_rsp[$];
    logic [DW-1:0] ref_mem[NREG];
    logic [DW-1:0] remote_mem[NREG];
    logic [DW-1:0] last_rdata = '0;

    // remote UART / responder state
    bit            busy = 0;
    logic [7:0]    cur_byte;
    int            tx_delay = 0;
    int            fixed_delay = 0;
    bit            spurious_en = 0;
    int            pstate = 0;
    logic [7:0]    pidx;
    int            pk = 0;
    logic [DW-1:0] pdata;
    int            rx_left = 0;
    int            rx_gap = 0;
    int            rx_k = 0;
    logic [7:0]    rx_idx;
    int            short_rx = 0;
    bit            hold_rx = 0;
    bit            r_sent = 0;
    int            last_rx_cycle = 0;
    int            rsp_seen = 0;
    int            rsp_cycle = 0;
    bit            chk_after = 0;

    task automatic parse_byte(input logic [7:0] b);
        case (pstate)
            0: pstate = (b == 8'h53) ? 1 : 0;
            1: begin pidx = b; pstate = 2; end
            2: begin
                if (b == 8'h57) begin
                    pstate = 3;
                    pk = 0;
                end else begin
                    pstate = 0;
                    r_sent = 1;
                    if (!hold_rx) begin
                        rx_left = (short_rx > 0) ? short_rx : N;
                        rx_idx  = pidx;
                        rx_k    = 0;
                        rx_gap  = $urandom_range(1, 3);
                    end
                end
            end
            default: begin
                pdata[8*pk +: 8] = b;
                pk++;
                if (pk == N) begin
                    remote_mem[pidx[2:0]] = pdata;
                    pstate = 0;
                end
            end
        endcase
    endtask

    // transmitter / receiver / responder model, plus tx byte checking
    always @(negedge clock) begin
        uart_tx_value_done  = 1'b0;
        uart_rx_value_ready = 1'b0;
        if (!arst_n) begin
            busy    = 0;
            pstate  = 0;
            rx_left = 0;
        end else begin
            if (uart_tx_value_write) begin
                check("tx_no_overlap", 64'(busy), 64'd0);
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected: got byte %02h, required no strobe", uart_tx_value);
                end else begin
                    check("tx_byte", 64'(uart_tx_value), 64'(exp_tx.pop_front()));
                end
                busy     = 1;
                cur_byte = uart_tx_value;
                tx_delay = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 4);
                if (spurious_en && $urandom_range(0, 2) == 0) uart_tx_value_done = 1'b1;
            end else if (busy) begin
                check("tx_stable", 64'(uart_tx_value), 64'(cur_byte));
                tx_delay--;
                if (tx_delay == 0) begin
                    uart_tx_value_done = 1'b1;
                    busy = 0;
                    parse_byte(cur_byte);
                end
            end
            if (rx_left > 0) begin
                if (rx_gap > 0) begin
                    rx_gap--;
                end else begin
                    uart_rx_value_ready = 1'b1;
                    uart_rx_value = remote_mem[rx_idx[2:0]][8*rx_k +: 8];
                    rx_k++;
                    rx_left--;
                    last_rx_cycle = cyc;
                    rx_gap = $urandom_range(0, 2);
                end
            end
        end
    end

    // response monitor
    always @(negedge clock) begin
        rsp_t e;
        if (!arst_n) begin
            chk_after = 0;
        end else begin
            if (chk_after) begin
                check("ready_after_rsp", 64'({req_ready, rsp_valid}), 64'b10);
                chk_after = 0;
            end
            if (rsp_valid) begin
                rsp_seen++;
                rsp_cycle = cyc;
                chk_after = 1;
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 err=%0b, required none", rsp_error);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_error", 64'(rsp_error), 64'(e.err));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    task automatic drive_req(input bit wr, input logic [7:0] idx, input logic [DW-1:0] wd);
        int guard;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = wr;
        req_index = idx;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) check("req_ready_wait", 64'(req_ready), 64'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        if (idx < NREG) check("accept_latency", 64'(uart_tx_value_write), 64'd1);
        else            check("bad_idx_latency", 64'({rsp_valid, rsp_error}), 64'b11);
    endtask

    task automatic push_tx(input bit wr, input logic [7:0] idx, input logic [DW-1:0] wd);
        exp_tx.push_back(8'h53);
        exp_tx.push_back(idx);
        exp_tx.push_back(wr ? 8'h57 : 8'h52);
        if (wr) for (int k = 0; k < N; k++) exp_tx.push_back(wd[8*k +: 8]);
    endtask

    task automatic do_req(input bit wr, input logic [7:0] idx, input logic [DW-1:0] wd, input int short_n);
        rsp_t          e;
        logic [DW-1:0] m;
        int            seen0;
        int            guard;
        if (idx < NREG) push_tx(wr, idx, wd);
        if (idx >= NREG) begin
            e.err = 1'b1; e.rdata = last_rdata;
        end else if (wr) begin
            ref_mem[idx[2:0]] = wd;
            e.err = 1'b0; e.rdata = last_rdata;
        end else if (short_n > 0) begin
            m = '0;
            for (int k = 0; k < short_n; k++) m[8*k +: 8] = 8'hFF;
            e.err = 1'b1; e.rdata = ref_mem[idx[2:0]] & m;
            last_rdata = e.rdata;
        end else begin
            e.err = 1'b0; e.rdata = ref_mem[idx[2:0]];
            last_rdata = e.rdata;
        end
        exp_rsp.push_back(e);
        short_rx = short_n;
        seen0 = rsp_seen;
        drive_req(wr, idx, wd);
        guard = 0;
        while (rsp_seen == seen0 && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        if (rsp_seen == seen0) begin
            check("rsp_wait", 64'(rsp_seen), 64'(seen0 + 1));
            void'(exp_rsp.pop_back());
        end
        short_rx = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic [7:0]    ix;
        bit            wr;
        int            guard;

        for (int k = 0; k < NREG; k++) begin
            ref_mem[k] = '0;
            remote_mem[k] = '0;
        end
        ref_mem[5]    = 32'h44332211;
        remote_mem[5] = 32'h44332211;

        repeat (3) @(negedge clock);
        check("reset_outputs", 64'({req_ready, rsp_valid, rsp_error, rsp_rdata, uart_tx_value, uart_tx_value_write}), 64'd0);
        arst_n = 1'b1;
        @(negedge clock);
        check("ready_after_reset", 64'(req_ready), 64'd1);

        fixed_delay = 3;
        do_req(1'b1, 8'd2, 32'hCAFEDECA, 0);
        do_req(1'b0, 8'd5, '0, 0);
        fixed_delay = 0;

        for (int k = 0; k < NREG; k++) do_req(1'b1, 8'(k), 32'hCAFEDECA + 32'(k) * 32'h01010101, 0);
        for (int k = 0; k < NREG; k++) do_req(1'b0, 8'(k), '0, 0);

        do_req(1'b1, 8'd8, 32'h12345678, 0);
        do_req(1'b0, 8'd255, '0, 0);

        spurious_en = 1;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            ix = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            d  = $urandom;
            do_req(wr, ix, d, 0);
        end
        spurious_en = 0;

`ifdef UART_REG_MASTER_TIMEOUT_EN
        do_req(1'b1, 8'd3, 32'h9999BBAA, 0);
        do_req(1'b0, 8'd3, '0, 2);
        check("timeout_delay_ok", 64'((rsp_cycle - last_rx_cycle) >= TO - 1 && (rsp_cycle - last_rx_cycle) <= TO + 3), 64'd1);
`endif

        // abort a read in RX_DATA with reset
        hold_rx = 1;
        r_sent  = 0;
        push_tx(1'b0, 8'd4, '0);
        drive_req(1'b0, 8'd4, '0);
        guard = 0;
        while (!r_sent && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        check("abort_r_sent", 64'(r_sent), 64'd1);
        repeat (2) @(negedge clock);
        arst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({req_ready, rsp_valid, rsp_error, rsp_rdata, uart_tx_value, uart_tx_value_write}), 64'd0);
        check("abort_tx_drained", 64'(exp_tx.size()), 64'd0);
        last_rdata = '0;
        repeat (3) @(negedge clock);
        hold_rx = 0;
        arst_n = 1'b1;
        @(negedge clock);
        d = $urandom;
        do_req(1'b1, 8'd6, d, 0);
        do_req(1'b0, 8'd6, '0, 0);

        repeat (5) @(negedge clock);
        check("rsp_drained", 64'(exp_rsp.size()), 64'd0);
        check("tx_drained", 64'(exp_tx.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
